// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment display driver: refresh prescaler, shadowed
// tear-free value updates, leading-zero suppression, PWM dimming and an
// anti-ghosting blank guard at the start of every digit slot.
module seven_seg_scanner #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter int unsigned BLANK_CYCLES   = 2,
  parameter int unsigned BRIGHT_W       = 4,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  load,
  input  logic [4*NUM_DIGITS-1:0]                               value,
  input  logic [NUM_DIGITS-1:0]                                 dp_in,
  input  logic [NUM_DIGITS-1:0]                                 blank_in,
  input  logic                                                  lz_suppress,
  input  logic [BRIGHT_W-1:0]                                   brightness,
  input  logic                                                  enable,
  output logic [NUM_DIGITS-1:0]                                 an,
  output logic [7:0]                                            seg,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
  output logic                                                  frame_tick,
  output logic                                                  update_pending
);

  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);
  localparam int unsigned VAL_W   = 4 * NUM_DIGITS;

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  pend_q, pend_d;
  logic [VAL_W-1:0]      shd_val_q, shd_val_d;
  logic [NUM_DIGITS-1:0] shd_dp_q, shd_dp_d;
  logic [NUM_DIGITS-1:0] shd_bl_q, shd_bl_d;
  logic [VAL_W-1:0]      act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] act_bl_q, act_bl_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;

  logic                  wrap_c;
  logic [3:0]            cur_nib_c;
  logic                  cur_dp_c;
  logic                  cur_bl_c;
  logic                  nz_above_c;
  logic                  supp_c;
  logic                  an_on_c;
  logic [NUM_DIGITS-1:0] an_raw_c;
  logic [7:0]            seg_raw_c;

  // Hex nibble to active-high {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Scan counters, shadow capture and frame-boundary commit
  always_comb begin
    presc_d      = presc_q + PRESC_W'(1);
    idx_d        = idx_q;
    pwm_d        = pwm_q + BRIGHT_W'(1);
    pend_d       = pend_q;
    shd_val_d    = shd_val_q;
    shd_dp_d     = shd_dp_q;
    shd_bl_d     = shd_bl_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_bl_d     = act_bl_q;
    wrap_c       = 1'b0;

    if (presc_q == PRESC_W'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d  = '0;
        wrap_c = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
    frame_tick_d = wrap_c;

    // Commit uses the pre-edge shadow; a coinciding load stays pending
    if (wrap_c && pend_q) begin
      act_val_d = shd_val_q;
      act_dp_d  = shd_dp_q;
      act_bl_d  = shd_bl_q;
      pend_d    = 1'b0;
    end
    if (load) begin
      shd_val_d = value;
      shd_dp_d  = dp_in;
      shd_bl_d  = blank_in;
      pend_d    = 1'b1;
    end
  end

  // Current digit select, leading-zero suppression, decode and anode gating
  always_comb begin
    cur_nib_c  = 4'h0;
    cur_dp_c   = 1'b0;
    cur_bl_c   = 1'b0;
    nz_above_c = 1'b0;
    an_raw_c   = '0;

    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) begin
        cur_nib_c = act_val_q[4*i +: 4];
        cur_dp_c  = act_dp_q[i];
        cur_bl_c  = act_bl_q[i];
      end
      if ((i >= 32'(idx_q)) && (act_val_q[4*i +: 4] != 4'h0)) begin
        nz_above_c = 1'b1;
      end
    end

    supp_c  = lz_suppress && (idx_q != '0) && !nz_above_c;
    an_on_c = enable && (presc_q >= PRESC_W'(BLANK_CYCLES)) &&
              !(cur_bl_c || supp_c) && (pwm_q <= brightness);

    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      an_raw_c[i] = an_on_c && (IDX_W'(i) == idx_q);
    end

    seg_raw_c = {cur_dp_c, hex_to_seg(cur_nib_c)};
    an_d      = (AN_ACTIVE_LOW != 0) ? ~an_raw_c : an_raw_c;
    seg_d     = (SEG_ACTIVE_LOW != 0) ? ~seg_raw_c : seg_raw_c;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      frame_tick_q <= 1'b0;
      pend_q       <= 1'b0;
      shd_val_q    <= '0;
      shd_dp_q     <= '0;
      shd_bl_q     <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_bl_q     <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      frame_tick_q <= frame_tick_d;
      pend_q       <= pend_d;
      shd_val_q    <= shd_val_d;
      shd_dp_q     <= shd_dp_d;
      shd_bl_q     <= shd_bl_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_bl_q     <= act_bl_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign an             = an_q;
  assign seg            = seg_q;
  assign digit_idx      = idx_q;
  assign frame_tick     = frame_tick_q;
  assign update_pending = pend_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a cycle-count based reference model
// pushes the expected outputs each clock; a negedge monitor pops and compares.
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 1;
  localparam int BW = 2;
  localparam int FRAME = RD * ND;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_in = 4'h0;
  logic        lz_suppress = 1'b0;
  logic [1:0]  brightness = 2'd3;
  logic        enable = 1'b1;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [1:0]  digit_idx;
  logic        frame_tick;
  logic        update_pending;

  seven_seg_scanner #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BRIGHT_W(BW),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .lz_suppress(lz_suppress), .brightness(brightness),
    .enable(enable), .an(an), .seg(seg), .digit_idx(digit_idx),
    .frame_tick(frame_tick), .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic [1:0] idx;
    logic       ft;
    logic       up;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: committed and shadow display contents per digit
  int   n = 0;
  int   act_nib[ND];
  int   act_dp[ND];
  int   act_bl[ND];
  int   shd_nib[ND];
  int   shd_dp[ND];
  int   shd_bl[ND];
  bit   pending = 0;
  logic [7:0] font [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  int   m_p, m_d, m_w;
  bit   m_supp, m_dark, m_on, m_wrap;
  exp_t m_e;

  // Model: after n clocks the scan position is pure arithmetic on n
  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0;
      pending = 0;
      for (int j = 0; j < ND; j++) begin
        act_nib[j] = 0; act_dp[j] = 0; act_bl[j] = 0;
        shd_nib[j] = 0; shd_dp[j] = 0; shd_bl[j] = 0;
      end
    end else begin
      n = n + 1;
      m_p = (n - 1) % RD;
      m_d = ((n - 1) / RD) % ND;
      m_w = (n - 1) % (1 << BW);
      m_supp = 0;
      if (lz_suppress && m_d != 0) begin
        m_supp = 1;
        for (int j = m_d; j < ND; j++) if (act_nib[j] != 0) m_supp = 0;
      end
      m_dark = (act_bl[m_d] != 0) || m_supp;
      m_on = enable && (m_p >= BC) && !m_dark && (m_w <= int'(brightness));
      m_e.an = 4'hF;
      if (m_on) m_e.an[m_d] = 1'b0;
      m_e.seg = ~(font[act_nib[m_d]] | ((act_dp[m_d] != 0) ? 8'h80 : 8'h00));
      m_wrap = (n % FRAME) == 0;
      if (m_wrap && pending) begin
        for (int j = 0; j < ND; j++) begin
          act_nib[j] = shd_nib[j]; act_dp[j] = shd_dp[j]; act_bl[j] = shd_bl[j];
        end
        pending = 0;
      end
      if (load) begin
        for (int j = 0; j < ND; j++) begin
          shd_nib[j] = int'(value[4*j +: 4]);
          shd_dp[j]  = int'(dp_in[j]);
          shd_bl[j]  = int'(blank_in[j]);
        end
        pending = 1;
      end
      m_e.idx = 2'((n / RD) % ND);
      m_e.ft  = m_wrap;
      m_e.up  = pending;
      q.push_back(m_e);
    end
  end

  exp_t got;
  exp_t want;

  // Monitor: compare DUT outputs against queued expectations away from the edge
  always @(negedge clk) begin
    got = {an, seg, digit_idx, frame_tick, update_pending};
    if (!rst_n) begin
      q.delete();
      checks++;
      if (got !== 16'hFF_F0 >> 0 && (an !== 4'hF || seg !== 8'hFF || digit_idx !== 2'd0 ||
          frame_tick !== 1'b0 || update_pending !== 1'b0)) begin
        errors++;
        $display("FAIL reset_state t=%0t: an=%h seg=%h idx=%0d ft=%b up=%b required an=f seg=ff idx=0 ft=0 up=0",
                 $time, an, seg, digit_idx, frame_tick, update_pending);
      end
    end else if (q.size() > 0) begin
      want = q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL scan_cycle n=%0d: got an=%h seg=%h idx=%0d ft=%b up=%b required an=%h seg=%h idx=%0d ft=%b up=%b",
                 n, got.an, got.seg, got.idx, got.ft, got.up,
                 want.an, want.seg, want.idx, want.ft, want.up);
      end
    end
  end

  task automatic at_neg();
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input int k);
    repeat (k) at_neg();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    load = 1'b1; value = v; dp_in = dp; blank_in = bl;
    at_neg();
    load = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int guard;
    guard = 0;
    while ((n % FRAME) != ph && guard < 2 * FRAME) begin
      at_neg();
      guard++;
    end
    if (guard >= 2 * FRAME) begin
      checks++;
      errors++;
      $display("FAIL wait_phase: phase %0d not reached, n=%0d", ph, n);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 8'hFF) begin
      errors++;
      $display("FAIL async_reset: an=%h seg=%h required an=f seg=ff", an, seg);
    end
    idle(3);
    rst_n = 1'b1;
  endtask

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(FRAME + 8);

    // Reset in the middle of a slot, then a zero frame
    idle(3);
    pulse_reset();
    idle(FRAME + 2);

    // Basic load with decimal point on digit 0
    do_load(16'h1234, 4'b0001, 4'b0000);
    idle(2 * FRAME);

    // Two loads in one frame: last one wins
    wait_phase(4);
    do_load(16'h1111, 4'b0000, 4'b0000);
    idle(3);
    do_load(16'hABCD, 4'b0000, 4'b0000);
    idle(2 * FRAME);

    // Load coinciding with the commit edge
    wait_phase(2);
    do_load(16'h2222, 4'b0000, 4'b0000);
    wait_phase(FRAME - 1);
    do_load(16'h5555, 4'b0000, 4'b0000);
    idle(3 * FRAME);

    // Leading-zero suppression
    lz_suppress = 1'b1;
    do_load(16'h0070, 4'b0000, 4'b0000);
    idle(2 * FRAME + 4);
    do_load(16'h0000, 4'b0000, 4'b0000);
    idle(2 * FRAME + 4);
    lz_suppress = 1'b0;

    // Brightness and enable
    do_load(16'h8F0E, 4'b1010, 4'b0100);
    brightness = 2'd0;
    idle(2 * FRAME);
    brightness = 2'd1;
    idle(FRAME);
    enable = 1'b0;
    idle(FRAME + 3);
    enable = 1'b1;
    brightness = 2'd3;
    idle(FRAME);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(15) == 0) begin
        load = 1'b1;
        value = 16'($urandom) >> (4 * $urandom_range(4));
        dp_in = 4'($urandom);
        blank_in = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(31) == 0) lz_suppress = ~lz_suppress;
      if ($urandom_range(31) == 0) brightness = 2'($urandom);
      if ($urandom_range(63) == 0) enable = ~enable;
      if (c == 300) pulse_reset();
      at_neg();
    end
    load = 1'b0;
    idle(2);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
